// File: rtl/store_responder.sv
// store_responder: acknowledges write-stage stores into a posted buffer and drains them in order to a wait-request bus.
module store_responder #(
  parameter int DEPTH = 4,
  parameter int AW = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   address_enable,
  input  logic [AW-1:0]          address,
  input  logic [AW-1:0]          data,
  output logic                   data_valid,
  output logic                   mem_write,
  output logic [AW-1:0]          mem_address,
  output logic [AW-1:0]          mem_data,
  input  logic                   mem_wait,
  output logic                   empty,
  output logic                   misaligned,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic {IDLE, ACK} state_t;
  state_t state, state_nx;
  logic [AW-1:0] addr_mem [DEPTH];
  logic [AW-1:0] data_mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic push, pop, full, bad;
  assign bad = address[1:0] != 2'b00;
  assign full = count == CW'(DEPTH);
  assign pop = mem_write && !mem_wait;
  assign mem_write = count != '0;
  assign empty = count == '0;
  assign data_valid = state == ACK;
  // Gated so the bus shows zeros, not stale buffer contents, while idle.
  assign mem_address = mem_write ? addr_mem[rd_ptr] : '0;
  assign mem_data = mem_write ? data_mem[rd_ptr] : '0;
  always_comb begin
    state_nx = IDLE;
    push = 1'b0;
    if (state == IDLE && address_enable && (bad || !full)) begin
      state_nx = ACK;
      push = !bad;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      misaligned <= 1'b0;
    end else begin
      state <= state_nx;
      misaligned <= misaligned || (state == IDLE && address_enable && bad);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clock) begin
    if (push) begin
      addr_mem[wr_ptr] <= {address[AW-1:2], 2'b00};
      data_mem[wr_ptr] <= data;
    end
  end
endmodule

// File: tb/tb_store_responder.sv
// tb_store_responder: randomized scoreboard bench; expected bus writes are queued at issue and checked by a bus monitor.
module tb_store_responder;
  localparam int DEPTH = 4;
  localparam int AW = 32;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic address_enable = 1'b0;
  logic [AW-1:0] address = '0;
  logic [AW-1:0] data = '0;
  logic mem_wait = 1'b1;
  logic data_valid, mem_write, empty, misaligned;
  logic [AW-1:0] mem_address, mem_data;
  logic [$clog2(DEPTH):0] count;
  int tests = 0;
  int fails = 0;
  int wait_mode = 0;
  logic [2*AW-1:0] exp_q[$];
  logic prev_dv = 1'b0;

  store_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock(clock), .reset_n(reset_n), .address_enable(address_enable),
    .address(address), .data(data), .data_valid(data_valid),
    .mem_write(mem_write), .mem_address(mem_address), .mem_data(mem_data),
    .mem_wait(mem_wait), .empty(empty), .misaligned(misaligned), .count(count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Every stimulus cycle goes through here so mem_wait has a single driver.
  task automatic tick();
    @(posedge clock);
    #1;
    if (wait_mode == 2) mem_wait = ~mem_wait;
    else if (wait_mode == 3) mem_wait = 1'($urandom_range(0, 1));
  endtask

  task automatic start_store(input logic [AW-1:0] a, input logic [AW-1:0] d);
    address = a;
    data = d;
    address_enable = 1'b1;
    if (a[1:0] == 2'b00) exp_q.push_back({a, d});
  endtask

  task automatic wait_ack(input int bound, output int lat);
    lat = -1;
    for (int i = 1; i <= bound; i++) begin
      tick();
      if (data_valid) begin
        lat = i;
        break;
      end
    end
    if (lat > 0) begin
      address_enable = 1'b0;
      tick();
    end
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [AW-1:0] d, output int lat);
    start_store(a, d);
    wait_ack(60, lat);
    if (lat < 0) begin
      chk("ack_timeout", 0, 1);
      address_enable = 1'b0;
    end
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (mem_write && !mem_wait) begin
        if (exp_q.size() == 0) chk("unexpected_bus_write", mem_address, '1);
        else begin
          logic [2*AW-1:0] e;
          e = exp_q.pop_front();
          chk("bus_address", mem_address, e[2*AW-1:AW] & ~32'h3);
          chk("bus_data", mem_data, e[AW-1:0]);
        end
      end
      if (prev_dv && data_valid) chk("data_valid_pulse", 2, 1);
      if (count > DEPTH) chk("count_bound", count, DEPTH);
      if (empty !== (count == 0)) chk("empty_flag", empty, count == 0);
      if (mem_write && mem_address[1:0] != 2'b00) chk("bus_aligned", mem_address[1:0], 0);
    end
    prev_dv = data_valid;
  end

  initial begin
    int lat;
    logic [AW-1:0] a;
    tick();
    tick();
    chk("rst_data_valid", data_valid, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_empty", empty, 1);
    chk("rst_misaligned", misaligned, 0);
    chk("rst_count", count, 0);
    reset_n = 1'b1;
    mem_wait = 1'b0;
    tick();

    start_store(32'h100, 32'hDEADBEEF);
    tick();
    chk("single_latency", data_valid, 1);
    chk("single_count", count, 1);
    chk("single_bus_addr", mem_address, 32'h100);
    chk("single_bus_data", mem_data, 32'hDEADBEEF);
    address_enable = 1'b0;
    tick();
    chk("single_empty", empty, 1);
    chk("single_count_after", count, 0);
    chk("single_ack_once", data_valid, 0);

    mem_wait = 1'b1;
    for (int i = 0; i < 4; i++) begin
      store(AW'(i * 4), $urandom, lat);
      chk("full_latency", lat, 1);
    end
    chk("full_count", count, 4);
    start_store(32'h10, $urandom);
    wait_ack(6, lat);
    chk("full_blocked", lat, -1);
    chk("full_count_held", count, 4);
    mem_wait = 1'b0;
    wait_ack(10, lat);
    chk("full_released", lat > 0, 1);
    for (int i = 0; i < 8; i++) tick();
    chk("full_drained", empty, 1);
    chk("full_queue_done", exp_q.size(), 0);

    mem_wait = 1'b1;
    store(32'h200, $urandom, lat);
    chk("simul_count_before", count, 1);
    mem_wait = 1'b0;
    start_store(32'h204, 32'h12345678);
    tick();
    chk("simul_ack", data_valid, 1);
    chk("simul_count", count, 1);
    chk("simul_next_addr", mem_address, 32'h204);
    chk("simul_next_data", mem_data, 32'h12345678);
    address_enable = 1'b0;
    tick();
    chk("simul_empty", empty, 1);

    store(32'h102, $urandom, lat);
    chk("mis_ack_latency", lat, 1);
    chk("mis_flag", misaligned, 1);
    chk("mis_count", count, 0);
    store(32'h104, 32'hCAFEF00D, lat);
    chk("mis_next_latency", lat, 1);
    chk("mis_sticky", misaligned, 1);
    tick();
    chk("mis_next_drained", empty, 1);

    mem_wait = 1'b1;
    for (int i = 0; i < 3; i++) store(32'h300 + AW'(i * 4), $urandom, lat);
    chk("rstmid_count_before", count, 3);
    reset_n = 1'b0;
    tick();
    exp_q.delete();
    chk("rstmid_count", count, 0);
    chk("rstmid_empty", empty, 1);
    chk("rstmid_mem_write", mem_write, 0);
    chk("rstmid_data_valid", data_valid, 0);
    chk("rstmid_misaligned", misaligned, 0);
    reset_n = 1'b1;
    mem_wait = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("rstmid_no_stale", mem_write, 0);

    wait_mode = 2;
    for (int i = 0; i < 10; i++) store({$urandom} & ~32'h3, $urandom, lat);
    wait_mode = 3;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      store(a, $urandom, lat);
    end
    wait_mode = 0;
    mem_wait = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("final_empty", empty, 1);
    chk("final_queue_done", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/store_responder.md
Name: store_responder

Overview:
- Memory-side responder for the write stage's store request interface (address_enable / address / data in, data_valid out).
- Accepts each store into a posted write buffer and acknowledges it with a one-cycle data_valid pulse, so the write stage stops holding the pipeline.
- Drains buffered stores in order to an external wait-request memory bus.
- Flags misaligned stores and drops them.

Parameters:
- DEPTH, 4, write buffer entries; power of two, at least 2.
- AW, 32, address and data width in bits.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  reset, synchronous, active-low.
- address_enable  input  1  store request from the write stage; held high until data_valid is seen.
- address  input  AW  byte address of the store; stable while address_enable is high.
- data  input  AW  store data; stable while address_enable is high.
- data_valid  output  1  store accepted; single-cycle pulse.
- mem_write  output  1  bus write strobe; high while the buffer is non-empty.
- mem_address  output  AW  bus byte address of the head entry; low two bits always 0.
- mem_data  output  AW  bus data of the head entry.
- mem_wait  input  1  bus wait request; the head entry is consumed on a cycle with mem_write=1 and mem_wait=0.
- empty  output  1  buffer empty; all accepted stores have left on the bus.
- misaligned  output  1  sticky: a store with address[1:0]!=0 was dropped.
- count  output  log2(DEPTH)+1  number of occupied buffer entries.

Behaviour:
- Reset: synchronous, active-low, sampled on the rising clock edge. Overrides all other activity, including an in-flight handshake or a stalled bus write. Buffered entries are discarded.
- Reset values: data_valid=0, mem_write=0, mem_address=0, mem_data=0, empty=1, misaligned=0, count=0; read/write pointers 0; acceptor FSM in IDLE.
- Acceptor FSM states: IDLE, ACK.
- IDLE, address_enable=1, buffer not full, address[1:0]=0:
  - Push {address, data} at the edge; go to ACK.
- IDLE, address_enable=1, address[1:0]!=0:
  - No push; set misaligned at the edge; go to ACK. The store is acknowledged and dropped.
- IDLE, address_enable=1, buffer full:
  - Stay in IDLE with no push. data_valid stays 0, so the write stage keeps holding.
  - A pop in the same cycle does not enable a push. The push happens on the first IDLE cycle in which the buffer is not full.
- IDLE, address_enable=0: stay in IDLE.
- ACK:
  - data_valid=1 for exactly this cycle.
  - address_enable is ignored; it is still high for the same store.
  - Unconditionally return to IDLE.
- Latency: the request is sampled at edge t and data_valid is high during the cycle after t. A new request arriving in the cycle right after ACK is accepted immediately, so the minimum store pitch is 2 cycles.
- data_valid comes straight from the FSM state register (registered), with no combinational path from address_enable.
- Drain side:
  - mem_write = (count != 0).
  - mem_address and mem_data present the head entry and are stable while mem_wait=1.
  - Pop when mem_write=1 and mem_wait=0.
  - Stores leave in acceptance order.
  - An entry pushed at edge t is visible on the bus from the cycle after t when the buffer was empty.
- count:
  - Push only: +1. Pop only: -1. Simultaneous push and pop (buffer not full): unchanged.
  - Never exceeds DEPTH and never underflows.
- Pointers: log2(DEPTH) bits, wrapping modulo DEPTH. Full is count==DEPTH; empty is count==0.
- misaligned: cleared only by reset.
- mem_address: address with bits [1:0] forced to 0; always aligned, since misaligned stores are never pushed.

Test Plan:
- Single store: DEPTH=4, address=0x100, data=0xDEADBEEF, mem_wait=0 → data_valid one cycle after the request. mem_write=1 with mem_address=0x100, mem_data=0xDEADBEEF for 1 cycle; then empty=1, count=0.
- Buffer full: mem_wait=1, 5 stores to 0x0,0x4,…,0x10, each held until acked → first 4 acked at 2-cycle pitch and count=4. Fifth sees data_valid=0 until mem_wait drops. After mem_wait=0, bus order is 0x0,0x4,0x8,0xC,0x10 and the fifth is acked.
- Simultaneous push/pop: count=1, mem_wait=0, new aligned store → count stays 1 across the edge, and the second store follows on the bus in the next cycle.
- Misaligned store: address=0x102 → data_valid pulses, misaligned=1 and stays 1, count unchanged, no bus write. A following store to 0x104 proceeds normally.
- Reset mid-operation: 3 entries buffered, mem_wait=1, reset_n=0 for 1 cycle → next cycle count=0, empty=1, mem_write=0, data_valid=0, misaligned=0. No stale entry appears after reset_n returns to 1.
- Wrap-around: 10 stores with mem_wait toggling every cycle → all 10 appear on the bus in order, with data matching and no duplicates.
